// File: rtl/adcv_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package     : adcv_pkg                                                  |
// | Description : Shared types and constants for the ADC sample            |
// |               decimator: raw code width, FSM states, and the layout of |
// |               an output buffer entry.                                  |
// | Options     : ADC_DECIM_MINMAX_EN adds window min/max to each entry.   |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
package adcv_pkg;

  // The raw code is the TDC fine value plus one extra bit.
  localparam int C_FINE_BITS = 9;
  localparam int C_IN_W      = C_FINE_BITS + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ACCUM  = 2'd2
  } adc_state_t;

  // One output buffer entry at the default code width.
  typedef struct packed {
    logic [C_IN_W-1:0] avg;
`ifdef ADC_DECIM_MINMAX_EN
    logic [C_IN_W-1:0] min;
    logic [C_IN_W-1:0] max;
`endif
  } adc_entry_t;

  // Flattened entry width for an arbitrary code width.
  function automatic int entry_width(input int in_w);
`ifdef ADC_DECIM_MINMAX_EN
    return 3 * in_w;
`else
    return in_w;
`endif
  endfunction

endpackage
`default_nettype wire

// File: rtl/adc_result_fifo.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : adc_result_fifo                                          |
// | Description : Two-entry in-order valid/ready buffer. A push into a     |
// |               full buffer with no simultaneous pop is dropped and      |
// |               flagged; push and pop together when full are accepted.   |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module adc_result_fifo #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             drop
);

  logic [1:0]       r_count;
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  logic             w_pop;
  logic             w_full;

  assign w_full    = (r_count == 2'd2);
  assign w_pop     = pop_ready && (r_count != 2'd0);
  assign drop      = push && w_full && !w_pop;
  assign out_valid = (r_count != 2'd0);
  assign out_data  = r_head;

  // Occupancy and storage update; the head register drives out_data directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 2'd0;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      case (r_count)
        2'd0: begin
          if (push) begin
            r_head  <= push_data;
            r_count <= 2'd1;
          end
        end
        2'd1: begin
          case ({push, w_pop})
            2'b11: r_head <= push_data;
            2'b10: begin
              r_tail  <= push_data;
              r_count <= 2'd2;
            end
            2'b01: r_count <= 2'd0;
            default: ;
          endcase
        end
        2'd2: begin
          if (w_pop) begin
            r_head <= r_tail;
            if (push) begin
              r_tail <= push_data;
            end else begin
              r_count <= 2'd1;
            end
          end
        end
        default: r_count <= 2'd0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/adc_sample_decimator.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : adc_sample_decimator                                     |
// | Description : Discards SETTLE samples after enable, then averages      |
// |               2^LOG2_DECIM raw codes with round-half-up and pushes     |
// |               each result into a 2-entry output buffer. Results that   |
// |               find the buffer full are dropped and counted.            |
// | Options     : ADC_DECIM_MINMAX_EN adds out_min/out_max per window.     |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module adc_sample_decimator
  import adcv_pkg::*;
#(
  parameter int IN_W       = C_IN_W,
  parameter int LOG2_DECIM = 2,
  parameter int SETTLE     = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IN_W-1:0]  out_data,
  output logic [CNT_W-1:0] overrun_cnt,
`ifdef ADC_DECIM_MINMAX_EN
  output logic [IN_W-1:0]  out_min,
  output logic [IN_W-1:0]  out_max,
`endif
  output logic             busy
);

  localparam int c_N       = 1 << LOG2_DECIM;
  localparam int c_ACC_W   = IN_W + LOG2_DECIM + 1;
  localparam int c_SCNT_W  = 9;
  localparam int c_ENTRY_W = entry_width(IN_W);

  localparam logic [c_ACC_W-1:0]  c_ROUND       = c_ACC_W'(c_N >> 1);
  localparam logic [c_SCNT_W-1:0] c_ACCUM_LAST  = c_SCNT_W'(c_N - 1);
  localparam logic [c_SCNT_W-1:0] c_SETTLE_LAST = c_SCNT_W'(SETTLE - 1);

  logic [1:0]           r_rst_sync;
  logic                 w_rst_n;
  adc_state_t           r_state;
  logic [c_ACC_W-1:0]   r_acc;
  logic [c_SCNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]     r_overrun;
  logic [c_ACC_W-1:0]   w_acc_next;
  logic [c_ACC_W-1:0]   w_sum;
  logic [IN_W-1:0]      w_avg;
  logic                 w_last;
  logic [c_ENTRY_W-1:0] w_entry;
  logic [c_ENTRY_W-1:0] w_fifo_data;
  logic                 w_drop;

  // Reset asserts asynchronously but releases on a clock edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  // The window sum never needs more than IN_W+LOG2_DECIM+1 bits, rounding included.
  assign w_acc_next = r_acc + c_ACC_W'(in_data);
  assign w_sum      = w_acc_next + c_ROUND;
  assign w_avg      = IN_W'(w_sum >> LOG2_DECIM);
  assign w_last     = enable && in_valid && (r_state == ST_ACCUM) && (r_cnt == c_ACCUM_LAST);

  // Run-control FSM with window accumulator and sample counter.
  always_ff @(posedge clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (!enable) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_acc   <= '0;
          r_cnt   <= '0;
          r_state <= (SETTLE > 0) ? ST_SETTLE : ST_ACCUM;
        end
        ST_SETTLE: begin
          if (in_valid) begin
            if (r_cnt == c_SETTLE_LAST) begin
              r_cnt   <= '0;
              r_state <= ST_ACCUM;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        ST_ACCUM: begin
          if (in_valid) begin
            if (w_last) begin
              r_acc <= '0;
              r_cnt <= '0;
            end else begin
              r_acc <= w_acc_next;
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_acc   <= '0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

`ifdef ADC_DECIM_MINMAX_EN
  logic [IN_W-1:0] r_min;
  logic [IN_W-1:0] r_max;
  logic [IN_W-1:0] w_win_min;
  logic [IN_W-1:0] w_win_max;

  // The first sample of a window loads both extremes.
  assign w_win_min = (r_cnt == '0) ? in_data : ((in_data < r_min) ? in_data : r_min);
  assign w_win_max = (r_cnt == '0) ? in_data : ((in_data > r_max) ? in_data : r_max);
  assign w_entry   = {w_avg, w_win_min, w_win_max};

  // Track window extremes for every accumulated sample.
  always_ff @(posedge clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_min <= '0;
      r_max <= '0;
    end else if (enable && in_valid && (r_state == ST_ACCUM)) begin
      r_min <= w_win_min;
      r_max <= w_win_max;
    end
  end

  assign out_min = w_fifo_data[2*IN_W-1 -: IN_W];
  assign out_max = w_fifo_data[IN_W-1:0];
`else
  assign w_entry = w_avg;
`endif

  adc_result_fifo #(
    .WIDTH (c_ENTRY_W)
  ) u_fifo (
    .clk       (clock),
    .rst_n     (w_rst_n),
    .push      (w_last),
    .push_data (w_entry),
    .pop_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (w_fifo_data),
    .drop      (w_drop)
  );

  assign out_data = w_fifo_data[c_ENTRY_W-1 -: IN_W];

  // Saturating count of results lost to a full buffer.
  always_ff @(posedge clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_overrun <= '0;
    end else if (w_drop && (r_overrun != '1)) begin
      r_overrun <= r_overrun + 1'b1;
    end
  end

  assign overrun_cnt = r_overrun;
  assign busy        = (r_state != ST_IDLE);

endmodule
`default_nettype wire
